// File: rtl/bin2bcd_digits_pkg.sv
// Shared types and constants for the sequential binary-to-BCD digit converter.
package bin2bcd_digits_pkg;

   localparam logic [4:0] CODE_BLANK = 5'h1D;
   localparam int         N_SHIFTS   = 16;
   localparam int         NUM_DIGITS = 5;
   localparam int         CNT_W      = $clog2(N_SHIFTS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FORMAT = 2'd2
   } state_t;

   typedef logic [4:0] digit_t;

endpackage

// File: rtl/bin2bcd_digits_if.sv
// Start/done handshake plus the five digit codes feeding the seven-segment driver.
interface bin2bcd_digits_if;
   import bin2bcd_digits_pkg::*;

   logic        start;
   logic [15:0] value;
   logic        blank_lz;
   logic        busy;
   logic        done;
   digit_t      d0;
   digit_t      d1;
   digit_t      d2;
   digit_t      d3;
   digit_t      d4;

   modport master (
      output start, value, blank_lz,
      input  busy, done, d0, d1, d2, d3, d4
   );

   modport slave (
      input  start, value, blank_lz,
      output busy, done, d0, d1, d2, d3, d4
   );

endinterface

// File: rtl/bin2bcd_digits_dd_add3.sv
// Double-dabble nibble correction: add 3 when the BCD nibble is 5 or more.
module bin2bcd_digits_dd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_digits.sv
// Sequential double-dabble converter: 16-bit binary to five digit codes, one shift per clock.
module bin2bcd_digits
   import bin2bcd_digits_pkg::*;
#(
   parameter logic [4:0] BLANK_CODE = CODE_BLANK
) (
   input logic              clk,
   input logic              reset,
   bin2bcd_digits_if.slave  bus
);

   // state  | meaning
   // IDLE   | waiting for start; digits hold last result
   // SHIFT  | 16 add-3/shift steps, one per clock
   // FORMAT | digits registered (with optional blanking), done pulsed

   state_t             state;
   logic [35:0]        sr;
   logic [CNT_W-1:0]   cnt;
   logic               blank_q;
   logic [19:0]        bcd_adj;
   logic [35:0]        sr_next;
   logic [NUM_DIGITS-1:0][4:0] fmt;
   logic               lead;
   logic [3:0]         nib;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
      bin2bcd_digits_dd_add3 u_add3 (
         .din  (sr[16 + 4*i +: 4]),
         .dout (bcd_adj[4*i +: 4])
      );
   end

   // Correction is applied to the BCD field before the shift, so the MSB of
   // the corrected field falls off; it is always zero for 16-bit inputs.
   assign sr_next = {bcd_adj[18:0], sr[15:0], 1'b0};

   always_comb begin
      fmt  = '0;
      lead = blank_q;
      nib  = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         nib = sr[16 + 4*i +: 4];
         if (lead && (nib == 4'd0)) begin
            fmt[i] = BLANK_CODE;
         end else begin
            fmt[i] = {1'b0, nib};
            lead   = 1'b0;
         end
      end
      fmt[0] = {1'b0, sr[19:16]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         sr       <= '0;
         cnt      <= '0;
         blank_q  <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.d0   <= '0;
         bus.d1   <= '0;
         bus.d2   <= '0;
         bus.d3   <= '0;
         bus.d4   <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  sr       <= {20'b0, bus.value};
                  blank_q  <= bus.blank_lz;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sr  <= sr_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(N_SHIFTS - 1)) begin
                  state <= ST_FORMAT;
               end
            end
            ST_FORMAT: begin
               bus.d0   <= fmt[0];
               bus.d1   <= fmt[1];
               bus.d2   <= fmt[2];
               bus.d3   <= fmt[3];
               bus.d4   <= fmt[4];
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Directed bench for bin2bcd_digits: scoreboard of expected digit codes and accept cycles.
module tb_bin2bcd_digits;
   import bin2bcd_digits_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bin2bcd_digits_if bus ();

   bin2bcd_digits dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [24:0] digits;
      int          accept_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_done   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits by division, then leading-zero blanking.
   function automatic logic [24:0] model(input int v, input logic bl);
      logic [4:0] c[5];
      int   t;
      logic lead;
      t = v;
      for (int i = 0; i < 5; i++) begin
         c[i] = 5'(t % 10);
         t    = t / 10;
      end
      lead = bl;
      for (int i = 4; i >= 1; i--) begin
         if (lead && c[i] == 5'd0) c[i] = 5'h1D;
         else lead = 1'b0;
      end
      return {c[4], c[3], c[2], c[1], c[0]};
   endfunction

   function automatic logic [24:0] dut_digits();
      return {bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
   endfunction

   exp_t mon_e;
   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("digits", 32'(dut_digits()), 32'(mon_e.digits));
            check("latency", 32'(cyc - mon_e.accept_cyc), 32'd17);
         end
      end
   end

   task automatic start_conv(input int v, input logic bl);
      exp_t e;
      @(negedge clk);
      bus.value    = 16'(v);
      bus.blank_lz = bl;
      bus.start    = 1'b1;
      e.digits     = model(v, bl);
      e.accept_cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.value    = 16'($urandom);
      bus.blank_lz = 1'($urandom_range(0, 1));
      check("busy_after_accept", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sb.size() != 0 || bus.busy !== 1'b0) && k < 80) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", 32'(k < 80), 32'd1);
   endtask

   initial begin
      int bc;
      int d0_cnt;
      bus.start    = 1'b0;
      bus.value    = '0;
      bus.blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_digits", 32'(dut_digits()), 32'd0);
      reset = 1'b0;

      // Full-scale value; busy must last exactly 17 cycles.
      d0_cnt = n_done;
      start_conv(16'hFFFF, 1'b0);
      bc = 1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) bc++;
         else break;
      end
      check("busy_cycles", 32'(bc), 32'd17);
      wait_idle();
      check("ffff_digits", 32'(dut_digits()), 32'({5'd6, 5'd5, 5'd5, 5'd3, 5'd5}));
      check("ffff_one_done", 32'(n_done - d0_cnt), 32'd1);

      start_conv(0, 1'b1);
      wait_idle();
      check("zero_blank", 32'(dut_digits()), 32'({5'h1D, 5'h1D, 5'h1D, 5'h1D, 5'h00}));
      start_conv(0, 1'b0);
      wait_idle();

      start_conv(1234, 1'b1);
      wait_idle();
      repeat (5) @(negedge clk);
      check("hold_1234", 32'(dut_digits()), 32'({5'h1D, 5'd1, 5'd2, 5'd3, 5'd4}));
      start_conv(10000, 1'b1);
      wait_idle();

      // Second start during busy must be ignored.
      d0_cnt = n_done;
      start_conv(42, 1'b0);
      repeat (4) @(negedge clk);
      bus.value = 16'd999;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);
      check("ignored_start_dones", 32'(n_done - d0_cnt), 32'd1);
      check("ignored_start_digits", 32'(dut_digits()), 32'(model(42, 1'b0)));

      // Reset mid-conversion aborts with no done pulse.
      d0_cnt = n_done;
      start_conv(500, 1'b0);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_digits", 32'(dut_digits()), 32'd0);
      sb.delete();
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_no_done", 32'(n_done - d0_cnt), 32'd0);
      start_conv(500, 1'b0);
      wait_idle();
      check("after_abort_500", 32'(dut_digits()), 32'({5'd0, 5'd0, 5'd5, 5'd0, 5'd0}));

      // Reset together with start: reset wins.
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.value = 16'd77;
      @(negedge clk);
      bus.start = 1'b0;
      reset     = 1'b0;
      check("reset_vs_start_busy", 32'(bus.busy), 32'd0);
      repeat (3) @(negedge clk);
      check("reset_vs_start_idle", 32'(bus.busy), 32'd0);

      // Start held high: back-to-back conversions every 18 clocks.
      begin
         exp_t e;
         int   c0;
         d0_cnt = n_done;
         @(negedge clk);
         c0           = cyc;
         bus.value    = 16'd7;
         bus.blank_lz = 1'b0;
         bus.start    = 1'b1;
         for (int j = 0; j < 3; j++) begin
            e.digits     = model(7, 1'b0);
            e.accept_cyc = c0 + 1 + 18 * j;
            sb.push_back(e);
         end
         repeat (54) @(negedge clk);
         bus.start = 1'b0;
         wait_idle();
         check("b2b_dones", 32'(n_done - d0_cnt), 32'd3);
         check("b2b_d0", 32'(bus.d0), 32'd7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
